// File: rtl/lane_motion_scheduler.sv
// Per-frame lane origin scheduler: one shared add/wrap unit steps each lane once per frame_tick.
// Optional frog carry output enabled by defining FROG_CARRY_EN.
module lane_motion_scheduler #(
    parameter int NUM_LANES    = 8,
    parameter int SCREEN_W     = 640,
    parameter int WRAP_MARGIN  = 80,
    parameter int SPEED_W      = 4,
    parameter int INIT_SPACING = 90
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_tick,
    input  logic                           freeze,
    input  logic [NUM_LANES*SPEED_W-1:0]   lane_speed,
    input  logic [NUM_LANES-1:0]           lane_dir,
    output logic [NUM_LANES*10-1:0]        lane_x,
    output logic                           busy,
    output logic                           update_done,
    output logic                           frame_overrun
`ifdef FROG_CARRY_EN
    ,
    input  logic [$clog2(NUM_LANES)-1:0]   frog_lane,
    input  logic                           frog_on_log,
    output logic signed [5:0]              frog_dx
`endif
);

    localparam int SPAN  = SCREEN_W + WRAP_MARGIN;
    localparam int IDX_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [9:0]         r_x [NUM_LANES];
    logic               r_overrun;

    logic               w_start;
    logic               w_last;
    logic [9:0]         w_cur_x;
    logic [SPEED_W-1:0] w_spd;
    logic               w_dir;
    logic [10:0]        w_x11;
    logic [10:0]        w_spd11;
    logic [10:0]        w_sum;
    logic [9:0]         w_new_x;

    function automatic logic [9:0] init_x(int unsigned i);
        return 10'((i * INIT_SPACING) % SPAN);
    endfunction

    assign w_start = (r_state == S_IDLE) && frame_tick && !freeze;
    assign w_last  = (r_idx == IDX_W'(NUM_LANES - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_RUN;
            S_RUN:   if (w_last)  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Shared wrap unit; speed/direction are read live for the lane in the slot.
    always_comb begin
        w_cur_x = r_x[r_idx];
        w_spd   = lane_speed[r_idx*SPEED_W +: SPEED_W];
        w_dir   = lane_dir[r_idx];
        w_x11   = {1'b0, w_cur_x};
        w_spd11 = 11'(w_spd);
        w_sum   = w_x11 + w_spd11;
        w_new_x = w_cur_x;
        if (w_dir) begin
            w_new_x = (w_sum >= 11'(SPAN)) ? 10'(w_sum - 11'(SPAN)) : w_sum[9:0];
        end else begin
            w_new_x = (w_spd11 > w_x11) ? 10'(w_x11 + 11'(SPAN) - w_spd11)
                                        : 10'(w_x11 - w_spd11);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_overrun <= 1'b0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                r_x[i] <= init_x(i);
            end
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_idx <= '0;
            end else if (r_state == S_RUN && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
            if (frame_tick && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
            if (r_state == S_RUN) begin
                r_x[r_idx] <= w_new_x;
            end
        end
    end

    always_comb begin
        lane_x = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_x[i*10 +: 10] = r_x[i];
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign update_done   = (r_state == S_DONE);
    assign frame_overrun = r_overrun;

`ifdef FROG_CARRY_EN
    logic signed [5:0] r_dx;
    logic [5:0]        w_mag;

    assign w_mag = 6'(w_spd);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dx <= '0;
        end else if (w_start) begin
            r_dx <= '0;
        end else if (r_state == S_RUN && r_idx == frog_lane && frog_on_log) begin
            r_dx <= w_dir ? w_mag : (6'd0 - w_mag);
        end
    end

    assign frog_dx = r_dx;
`endif

endmodule

// File: tb/tb_lane_motion_scheduler.sv
// Directed bench for lane_motion_scheduler with a per-cycle timeline model.
// Define FROG_CARRY_EN to also exercise the frog carry port.
module tb_lane_motion_scheduler;

    localparam int N    = 8;
    localparam int SPAN = 720;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           frame_tick = 1'b0;
    logic           freeze = 1'b0;
    logic [N*4-1:0] lane_speed = '0;
    logic [N-1:0]   lane_dir = '0;
    logic [N*10-1:0] lane_x;
    logic           busy;
    logic           update_done;
    logic           frame_overrun;
`ifdef FROG_CARRY_EN
    logic [2:0]        frog_lane = 3'd0;
    logic              frog_on_log = 1'b0;
    logic signed [5:0] frog_dx;
`endif

    lane_motion_scheduler #(
        .NUM_LANES(N), .SCREEN_W(640), .WRAP_MARGIN(80), .SPEED_W(4), .INIT_SPACING(90)
    ) dut (
        .Clk(clk), .Reset(reset), .frame_tick(frame_tick), .freeze(freeze),
        .lane_speed(lane_speed), .lane_dir(lane_dir), .lane_x(lane_x),
        .busy(busy), .update_done(update_done), .frame_overrun(frame_overrun)
`ifdef FROG_CARRY_EN
        , .frog_lane(frog_lane), .frog_on_log(frog_on_log), .frog_dx(frog_dx)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lx(int i);
        return int'(lane_x[i*10 +: 10]);
    endfunction

    // Model: a sweep is a timeline position; slot p (0..N-1) moves lane p modulo SPAN,
    // slot N is the done cycle.
    int m_x [N];
    int m_pos = -1;
    int m_ovr = 0;
    int m_dx = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_x[i] = (i * 90) % SPAN;
            m_pos = -1; m_ovr = 0; m_dx = 0; m_valid = 1;
        end else begin
            if (frame_tick && m_pos >= 0) m_ovr = 1;
            if (m_pos >= 0 && m_pos < N) begin
                int s;
                s = lane_dir[m_pos] ? int'(lane_speed[m_pos*4 +: 4]) : -int'(lane_speed[m_pos*4 +: 4]);
                m_x[m_pos] = (m_x[m_pos] + s + SPAN) % SPAN;
`ifdef FROG_CARRY_EN
                if (int'(frog_lane) == m_pos && frog_on_log) m_dx = s;
`endif
            end
            if (m_pos == N) m_pos = -1;
            else if (m_pos >= 0) m_pos++;
            else if (frame_tick && !freeze) begin
                m_pos = 0; m_dx = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < N; i++) check($sformatf("model lane_x[%0d]", i), lx(i), m_x[i]);
            check("model busy", int'(busy), int'(m_pos >= 0));
            check("model update_done", int'(update_done), int'(m_pos == N));
            check("model frame_overrun", int'(frame_overrun), m_ovr);
`ifdef FROG_CARRY_EN
            check("model frog_dx", int'(frog_dx), m_dx);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(int i, int spd, bit dir);
        lane_speed[i*4 +: 4] = 4'(spd);
        lane_dir[i] = dir;
    endtask

    task automatic run_frame();
        int n;
        n = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        while (!update_done && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check("update_done timeout", 0, 1);
        step();
    endtask

    int init_exp [N] = '{0, 90, 180, 270, 360, 450, 540, 630};

    initial begin
        // 1: reset state
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) check($sformatf("init lane_x[%0d]", i), lx(i), init_exp[i]);
        check("init busy", int'(busy), 0);
        check("init overrun", int'(frame_overrun), 0);
        step();

        // 2: first sweep timing
        set_lane(0, 5, 1'b1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("T busy", int'(busy), 1);
        check("T lane0", lx(0), 0);
        step();
        check("T+1 lane0", lx(0), 5);
        for (int k = 2; k <= 7; k++) step();
        check("T+7 update_done", int'(update_done), 0);
        step();
        check("T+8 update_done", int'(update_done), 1);
        step();
        check("T+9 update_done", int'(update_done), 0);
        check("T+9 busy", int'(busy), 0);
        set_lane(0, 0, 1'b0);

        // 3: right wrap with exact landing, left exact landing then wrap
        set_lane(7, 15, 1'b1);
        run_frame(); check("lane7 f1", lx(7), 645);
        run_frame(); check("lane7 f2", lx(7), 660);
        run_frame(); check("lane7 f3", lx(7), 675);
        run_frame(); run_frame(); run_frame();
        check("lane7 exact wrap", lx(7), 0);
        set_lane(7, 0, 1'b0);
        set_lane(1, 10, 1'b0);
        for (int k = 0; k < 9; k++) run_frame();
        check("lane1 exact zero", lx(1), 0);
        run_frame();
        check("lane1 left wrap", lx(1), 710);
        set_lane(1, 0, 1'b0);

        // mid-sweep change only affects lanes not yet processed
        set_lane(5, 2, 1'b1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(); step();
        set_lane(5, 4, 1'b0);
        for (int k = 0; k < 8; k++) step();
        check("lane5 late sample", lx(5), 446);
        set_lane(5, 0, 1'b0);

        // 4: overrun
        set_lane(3, 1, 1'b1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(); step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("overrun set", int'(frame_overrun), 1);
        for (int k = 0; k < 10; k++) step();
        check("overrun dropped tick", lx(3), 271);
        run_frame();
        check("overrun sticky", int'(frame_overrun), 1);

        // 5: freeze, then reset mid-sweep
        freeze = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        freeze = 1'b0;
        check("freeze busy", int'(busy), 0);
        step();
        check("freeze update_done", int'(update_done), 0);
        check("freeze lane0", lx(0), 5);
        set_lane(0, 3, 1'b1);
        set_lane(2, 4, 1'b0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) check($sformatf("abort lane_x[%0d]", i), lx(i), init_exp[i]);
        check("abort busy", int'(busy), 0);
        check("abort overrun", int'(frame_overrun), 0);

        // tick landing on the done cycle is an overrun
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("pre-done overrun", int'(frame_overrun), 0);
        step();
        check("done cycle", int'(update_done), 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("done-cycle overrun", int'(frame_overrun), 1);
        check("done-cycle idle", int'(busy), 0);
        step();

`ifdef FROG_CARRY_EN
        // 6: frog carry
        set_lane(0, 0, 1'b0);
        set_lane(2, 0, 1'b0);
        set_lane(3, 7, 1'b0);
        frog_lane = 3'd3;
        frog_on_log = 1'b1;
        run_frame();
        check("frog_dx left", int'(frog_dx), -7);
        frog_on_log = 1'b0;
        run_frame();
        check("frog_dx off log", int'(frog_dx), 0);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
